// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state encoding and parity mode constants
package parity_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, REPORT} state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
endpackage

// File: rtl/parity_frame_ctrl_if.sv
// parity_frame_ctrl_if: serial bit input and frame result bundle
interface parity_frame_ctrl_if #(parameter int DATA_W = 8, parameter int CNT_W = 8);
  logic bit_in;
  logic bit_valid;
  logic odd_mode;
  logic abort;
  logic [DATA_W-1:0] word_out;
  logic word_valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  logic [CNT_W-1:0] err_count;
  modport master (output bit_in, bit_valid, odd_mode, abort,
                  input word_out, word_valid, parity_err, frame_err, busy, err_count);
  modport slave (input bit_in, bit_valid, odd_mode, abort,
                 output word_out, word_valid, parity_err, frame_err, busy, err_count);
endinterface

// File: rtl/serial_parity_acc.sv
// serial_parity_acc: one-flop running parity, clear wins over enable
module serial_parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic parity
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) parity <= 1'b0;
    else if (clr) parity <= 1'b0;
    else if (en && bit_in) parity <= ~parity;
endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: framed serial receiver with parity/framing check and error count
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  parity_frame_ctrl_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [DATA_W-1:0] shreg, word_out;
  logic [CNT_W-1:0] err_count;
  logic odd_l, mismatch, parity, word_valid, parity_err, frame_err;
  logic v, bin, start, tout, fire, perr, ferr;
  assign v = bus.bit_valid;
  assign bin = bus.bit_in;
  assign bus.word_out = word_out;
  assign bus.word_valid = word_valid;
  assign bus.parity_err = parity_err;
  assign bus.frame_err = frame_err;
  assign bus.err_count = err_count;
  assign bus.busy = state != IDLE;
  serial_parity_acc u_acc (
    .clk(clk), .reset(reset), .clr(start), .en(state == DATA && v), .bit_in(bin), .parity(parity)
  );
  always_comb begin
    nxt = state;
    start = state == IDLE && v && !bin && !bus.abort;
    tout = (state == DATA || state == PAR || state == STOP) && !v && tmo == TW'(TIMEOUT - 1);
    case (state)
      IDLE: nxt = (v && !bin) ? DATA : IDLE;
      DATA: nxt = (v && cnt == CW'(DATA_W - 1)) ? PAR : DATA;
      PAR: nxt = v ? STOP : PAR;
      STOP: nxt = v ? REPORT : STOP;
      default: nxt = IDLE;
    endcase
    nxt = bus.abort ? IDLE : tout ? REPORT : nxt;
    fire = nxt == REPORT;
    perr = !tout && mismatch;
    ferr = tout || !bin;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      tmo <= '0;
      shreg <= '0;
      odd_l <= 1'b0;
      mismatch <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      tmo <= (v || state == IDLE || state == REPORT) ? '0 : tmo + TW'(1);
      if (start) begin
        cnt <= '0;
        shreg <= '0;
        odd_l <= bus.odd_mode;
      end
      if (state == DATA && v) begin
        shreg[cnt] <= bin;
        cnt <= cnt + CW'(1);
      end
      if (state == PAR && v) mismatch <= parity ^ bin ^ odd_l;
      word_valid <= fire;
      if (fire) begin
        word_out <= shreg;
        parity_err <= perr;
        frame_err <= ferr;
        if ((perr || ferr) && err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed frame vectors with assertion checks
module tb_parity_frame_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int passed = 0;
  int n;
  parity_frame_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus ();
  parity_frame_ctrl #(.DATA_W(8), .TIMEOUT(64), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic send_bit(input logic b);
    bus.bit_in = b;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask
  task automatic report(input string tag, input logic [7:0] wo, input logic pe, input logic fe, input logic [7:0] ec);
    chk({tag, "_wv"}, 32'(bus.word_valid), 32'd1);
    chk({tag, "_wo"}, 32'(bus.word_out), 32'(wo));
    chk({tag, "_pe"}, 32'(bus.parity_err), 32'(pe));
    chk({tag, "_fe"}, 32'(bus.frame_err), 32'(fe));
    chk({tag, "_ec"}, 32'(bus.err_count), 32'(ec));
    @(posedge clk);
    #1;
    chk({tag, "_wv_off"}, 32'(bus.word_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.bit_in = 1'b1;
    bus.bit_valid = 1'b0;
    bus.odd_mode = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wo", 32'(bus.word_out), 32'd0);
    chk("rst_wv", 32'(bus.word_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ec", 32'(bus.err_count), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'hA5, 1'b0, 1'b1);
    report("even_ok", 8'hA5, 1'b0, 1'b0, 8'd0);
    send_frame(8'hA5, 1'b1, 1'b1);
    report("even_bad", 8'hA5, 1'b1, 1'b0, 8'd1);
    bus.odd_mode = 1'b1;
    send_bit(1'b0);
    bus.odd_mode = 1'b0;
    send_bit(1'b1);
    for (int i = 1; i < 8; i++) send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    report("odd_ok", 8'h01, 1'b0, 1'b0, 8'd1);
    send_frame(8'h3C, 1'b0, 1'b0);
    report("stop_bad", 8'h3C, 1'b0, 1'b1, 8'd2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n = 0;
    while (!bus.word_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd64);
    report("tmo", 8'h05, 1'b0, 1'b1, 8'd3);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.abort = 1'b1;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.bit_valid = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_wv", 32'(bus.word_valid), 32'd0);
    chk("abort_ec", 32'(bus.err_count), 32'd3);
    send_frame(8'h5A, 1'b0, 1'b1);
    report("post_abort", 8'h5A, 1'b0, 1'b0, 8'd3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_wo", 32'(bus.word_out), 32'd0);
    chk("mid_rst_ec", 32'(bus.err_count), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_fe", 32'(bus.frame_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b1);
    report("post_rst", 8'hC3, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 255; i++) begin
      send_frame(8'hFF, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("sat_255", 32'(bus.err_count), 32'd255);
    for (int i = 0; i < 45; i++) begin
      send_frame(8'hFF, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("sat_hold", 32'(bus.err_count), 32'd255);
    chk("sat_pe", 32'(bus.parity_err), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
Serial frame receiver/controller that sequences a bit-serial parity tracker across a framed bitstream: start bit, DATA_W data bits (LSB first), one parity bit, one stop bit. Assembles the data word, checks parity (even/odd selectable) and framing, and reports each frame as a one-cycle result pulse. Sits between a serial bit source (bit_valid strobe per bit) and the word-level consumer; also keeps a saturating error count for status readout.

Parameters:
DATA_W, 8, data bits per frame (2..32)
TIMEOUT, 64, max clk cycles between bit_valid strobes inside a frame before abort (>=2)
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
bit_in  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  one-cycle strobe: bit_in holds a new bit
odd_mode  input  1  0=even parity, 1=odd parity; sampled at start-bit acceptance, held for the frame
abort  input  1  synchronous frame abort, returns to IDLE
word_out  output  DATA_W  last received data word
word_valid  output  1  one-cycle pulse: frame result available
parity_err  output  1  parity mismatch for frame reported by word_valid
frame_err  output  1  stop bit 0 or timeout for the reported frame
busy  output  1  1 in any state other than IDLE
err_count  output  CNT_W  saturating count of frames with parity_err or frame_err

Behaviour:
- One clock clk; reset is asynchronous and active-low (reset=0 forces reset immediately, independent of clk). Reset values: state=IDLE, word_out=0, word_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0, bit counter=0, timeout counter=0.
- States: IDLE, DATA, PAR, STOP, REPORT.
- IDLE: bit_valid&&bit_in==0 (start bit) -> DATA; clear bit counter, shift reg, parity tracker; latch odd_mode. bit_valid&&bit_in==1 ignored (line idle).
- DATA: each bit_valid shifts bit_in into bit [count] of shift reg (LSB first), parity tracker toggles on 1, count++. Strobe with count==DATA_W-1 -> PAR.
- PAR: bit_valid: mismatch = tracker ^ bit_in ^ odd_latched (1 = error); latch -> STOP.
- STOP: bit_valid: stop_bad = ~bit_in; -> REPORT.
- REPORT (one cycle): word_out<=shift reg, parity_err<=mismatch, frame_err<=stop_bad, word_valid=1 for this cycle only; err_count+1 if either error, saturate at 2^CNT_W-1; -> IDLE. Latency: word_valid the cycle after the stop-bit strobe.
- word_valid registered output, exactly one cycle per frame. word_out/parity_err/frame_err hold until next report.
- bit_valid during REPORT ignored (not a start bit); source must leave >=1 cycle gap after the stop bit.
- Timeout: counter clears on every bit_valid and on entry to DATA; increments in DATA/PAR/STOP. Reaching TIMEOUT -> REPORT with frame_err=1, parity_err=0, word_out=partial shift reg (unreceived bits 0); counts as error.
- abort=1 in any state: -> IDLE next cycle, no report, outputs and err_count unchanged; abort beats bit_valid same cycle.
- Reset mid-frame: frame discarded, all reset values.
- busy=1 in DATA, PAR, STOP, REPORT.

Decomposition:
- Shared package parity_pkg: state enum (IDLE, DATA, PAR, STOP, REPORT), PARITY_EVEN/PARITY_ODD constants.
- One sub-module: serial_parity_acc (clk, reset, clr, en, bit, parity): one-flop toggle tracker, parity flips when en&&bit; clr has priority over en.

Test Plan:
- Even mode, frame start 0, data 0xA5 LSB first, parity 0, stop 1 -> word_valid pulse 1 cycle after stop strobe, word_out=0xA5, parity_err=0, frame_err=0, err_count=0.
- Same frame, parity bit 1 -> word_out=0xA5, parity_err=1, err_count=1; odd_mode=1 with data 0x01, parity 0 -> parity_err=0.
- Data 0x3C, parity 0, stop 0 -> frame_err=1, parity_err=0, err_count increments.
- Start + 3 data bits then no strobes -> after TIMEOUT=64 idle cycles word_valid pulses, frame_err=1, busy returns 0 next cycle.
- abort after 4 data bits, then full frame 0x5A -> no pulse for aborted frame; one pulse with 0x5A clean. Reset=0 mid-frame -> all outputs 0 immediately, next frame received normally.
- 300 parity-error frames with CNT_W=8 -> err_count saturates at 255, no wrap.
